// File: rtl/uart_bus_master.sv
// uart_bus_master: serial debug bridge that turns host command frames on
// ser_rx into single 32-bit PicoRV32 native-bus transactions and returns
// the result on ser_tx.
module uart_bus_master #(
    parameter int BAUD_DIV     = 104,
    parameter int BUS_TIMEOUT  = 1024,
    parameter int IDLE_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ser_rx,
    output logic        ser_tx,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int BW = $clog2(BAUD_DIV + 1);
    localparam int TW = $clog2(BUS_TIMEOUT + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] BUS_LAST  = TW'(BUS_TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_BUS  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    // receiver state
    logic          rx_meta, rx_sync, rx_prev;
    logic [1:0]    rx_state;
    logic [BW-1:0] rx_cnt;
    logic [2:0]    rx_bitn;
    logic [7:0]    rx_shift;
    logic          rx_strobe;

    // parser / transmitter state
    logic [2:0]    state;
    logic          is_write;
    logic [1:0]    byte_cnt;
    logic [IW-1:0] idle_tmr;
    logic [TW-1:0] bus_tmr;
    logic [31:0]   resp_buf;
    logic [2:0]    resp_left;
    logic          tx_active;
    logic [BW-1:0] tx_cnt;
    logic [3:0]    tx_bit;

    assign busy = (state != S_IDLE);

    // Receiver: 2-flop synchroniser, start-edge detect, mid-bit sampling.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bitn   <= '0;
            rx_shift  <= '0;
            rx_strobe <= 1'b0;
        end else begin
            rx_meta   <= ser_rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            rx_strobe <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bitn  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bitn  <= rx_bitn + 1'b1;
                        if (rx_bitn == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt    <= '0;
                        rx_state  <= RX_IDLE;
                        rx_strobe <= rx_sync;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Command parser, bus initiator and response transmitter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            is_write  <= 1'b0;
            byte_cnt  <= '0;
            idle_tmr  <= '0;
            bus_tmr   <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            resp_buf  <= '0;
            resp_left <= '0;
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            ser_tx    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_strobe) begin
                        byte_cnt <= '0;
                        idle_tmr <= '0;
                        if (rx_shift == 8'h57) begin
                            is_write <= 1'b1;
                            state    <= S_ADDR;
                        end else if (rx_shift == 8'h52) begin
                            is_write <= 1'b0;
                            state    <= S_ADDR;
                        end else begin
                            resp_buf  <= 32'h0000_003F;
                            resp_left <= 3'd1;
                            state     <= S_RESP;
                        end
                    end
                end
                S_ADDR, S_DATA: begin
                    if (rx_strobe) begin
                        // little-endian: shifting in from the top leaves byte 0 at [7:0]
                        idle_tmr <= '0;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (state == S_ADDR)
                            mem_addr <= {rx_shift, mem_addr[31:8]};
                        else
                            mem_wdata <= {rx_shift, mem_wdata[31:8]};
                        if (byte_cnt == 2'd3) begin
                            if (state == S_ADDR && is_write) begin
                                state <= S_DATA;
                            end else begin
                                state     <= S_BUS;
                                mem_valid <= 1'b1;
                                mem_wstrb <= {4{is_write}};
                                bus_tmr   <= '0;
                            end
                        end
                    end else if (idle_tmr == IDLE_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        idle_tmr <= idle_tmr + 1'b1;
                    end
                end
                S_BUS: begin
                    // ready on the timeout edge still wins
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= S_RESP;
                        if (is_write) begin
                            resp_buf  <= 32'h0000_004B;
                            resp_left <= 3'd1;
                        end else begin
                            resp_buf  <= mem_rdata;
                            resp_left <= 3'd4;
                        end
                    end else if (bus_tmr == BUS_LAST) begin
                        mem_valid <= 1'b0;
                        resp_buf  <= 32'h0000_0054;
                        resp_left <= 3'd1;
                        state     <= S_RESP;
                    end else begin
                        bus_tmr <= bus_tmr + 1'b1;
                    end
                end
                S_RESP: begin
                    if (!tx_active) begin
                        tx_active <= 1'b1;
                        tx_cnt    <= '0;
                        tx_bit    <= '0;
                        ser_tx    <= 1'b0;
                    end else if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            if (resp_left == 3'd1) begin
                                tx_active <= 1'b0;
                                state     <= S_IDLE;
                            end else begin
                                resp_buf  <= {8'h00, resp_buf[31:8]};
                                resp_left <= resp_left - 1'b1;
                                tx_bit    <= '0;
                                ser_tx    <= 1'b0;
                            end
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                            ser_tx <= (tx_bit == 4'd8) ? 1'b1 : resp_buf[tx_bit[2:0]];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: scoreboard bench; stimulus pushes expected bus
// transactions and TX bytes, independent monitors pop and compare.
module tb_uart_bus_master;

    localparam int BD = 8;
    localparam int BT = 20;
    localparam int IT = 400;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          dur;
    } bus_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ser_rx;
    logic        ser_tx;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rst_cnt = 0;

    logic [7:0] exp_tx[$];
    bus_t       exp_bus[$];
    int         tx_starts[$];

    int          rdy_dly = 0;
    logic [31:0] rdata_cfg = '0;

    uart_bus_master #(
        .BAUD_DIV(BD),
        .BUS_TIMEOUT(BT),
        .IDLE_TIMEOUT(IT)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .ser_rx(ser_rx),
        .ser_tx(ser_tx),
        .mem_valid(mem_valid),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (resetn === 1'b0)
            rst_cnt <= rst_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        ser_rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (BD) @(negedge clk);
        end
        ser_rx = stop_bit;
        repeat (BD) @(negedge clk);
        ser_rx = 1'b1;
        if (!stop_bit)
            repeat (2 * BD) @(negedge clk);
    endtask

    task automatic send4(input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic push_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int dur);
        bus_t e;
        e.addr = a;
        e.wdata = d;
        e.wstrb = s;
        e.dur = dur;
        exp_bus.push_back(e);
    endtask

    task automatic wait_idle(output int fall_cyc);
        int n;
        n = 0;
        fall_cyc = -1;
        while (!(busy === 1'b0 && exp_tx.size() == 0) && n < 5000) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0 && fall_cyc < 0)
                fall_cyc = cyc;
        end
        check("idle_wait_bound", 64'(n < 5000), 64'd1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (mem_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mem_valid_wait_bound", 64'(n < 2000), 64'd1);
    endtask

    // Responder: raises mem_ready after rdy_dly cycles of mem_valid (-1 = never).
    initial begin : responder
        int rcnt;
        rcnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1 && !mem_ready) begin
                if (rdy_dly >= 0 && rcnt == rdy_dly) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata_cfg;
                end
                rcnt++;
            end else begin
                mem_ready = 1'b0;
                rcnt = 0;
            end
        end
    end

    // Bus monitor: one expected entry per mem_valid pulse.
    initial begin : bus_mon
        bus_t e;
        int   dur;
        int   r0;
        logic stable;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1) begin
                vectors++;
                if (exp_bus.size() == 0) begin
                    miscompares++;
                    $display("FAIL bus_unexpected: got addr %0h wstrb %0h expected no transaction", mem_addr, mem_wstrb);
                    e.addr = mem_addr; e.wdata = mem_wdata; e.wstrb = mem_wstrb; e.dur = -1;
                end else begin
                    e = exp_bus.pop_front();
                end
                check("bus_addr", 64'(mem_addr), 64'(e.addr));
                check("bus_wdata", 64'(mem_wdata), 64'(e.wdata));
                check("bus_wstrb", 64'(mem_wstrb), 64'(e.wstrb));
                r0 = rst_cnt;
                dur = 0;
                stable = 1'b1;
                while (mem_valid === 1'b1 && dur < 5000) begin
                    if (mem_addr !== e.addr || mem_wdata !== e.wdata || mem_wstrb !== e.wstrb)
                        stable = 1'b0;
                    dur++;
                    @(negedge clk);
                end
                check("bus_stable", 64'(stable), 64'd1);
                if (rst_cnt == r0 && e.dur >= 0)
                    check("bus_valid_cycles", 64'(dur), 64'(e.dur));
            end
        end
    end

    // TX monitor: decodes each frame, checks every bit is held BD cycles.
    initial begin : tx_mon
        logic [9:0] bits;
        logic       stable;
        int         r0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (ser_tx === 1'b0 && resetn === 1'b1) begin
                r0 = rst_cnt;
                tx_starts.push_back(cyc);
                stable = 1'b1;
                bits = '0;
                for (int i = 0; i < 10 * BD; i++) begin
                    if (i > 0)
                        @(negedge clk);
                    if (i % BD == 0)
                        bits[i / BD] = ser_tx;
                    else if (ser_tx !== bits[i / BD])
                        stable = 1'b0;
                end
                if (rst_cnt == r0) begin
                    vectors++;
                    if (exp_tx.size() == 0) begin
                        miscompares++;
                        $display("FAIL tx_unexpected: got byte %0h expected none", bits[8:1]);
                    end else begin
                        e = exp_tx.pop_front();
                        check("tx_byte", 64'(bits[8:1]), 64'(e));
                    end
                    check("tx_stop_bit", 64'(bits[9]), 64'd1);
                    check("tx_bit_width", 64'(stable), 64'd1);
                end
            end
        end
    end

    initial begin : main
        int fall;
        int any_busy;

        resetn = 1'b0;
        ser_rx = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_ser_tx", 64'(ser_tx), 64'd1);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // write, ready after 3 cycles of valid
        rdy_dly = 3;
        push_bus(32'h0200_0010, 32'hDEAD_BEEF, 4'hF, 4);
        exp_tx.push_back(8'h4B);
        send_byte(8'h57, 1'b1);
        send4(32'h0200_0010);
        send4(32'hDEAD_BEEF);
        wait_idle(fall);

        // read, immediate ready, 4-byte back-to-back response
        rdy_dly = 0;
        rdata_cfg = 32'h1234_5678;
        push_bus(32'h0000_0004, 32'hDEAD_BEEF, 4'h0, 1);
        exp_tx.push_back(8'h78);
        exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h12);
        tx_starts.delete();
        send_byte(8'h52, 1'b1);
        send4(32'h0000_0004);
        wait_idle(fall);
        check("read_tx_count", 64'(tx_starts.size()), 64'd4);
        if (tx_starts.size() == 4) begin
            for (int k = 0; k < 3; k++)
                check("read_back_to_back", 64'(tx_starts[k+1] - tx_starts[k]), 64'(10 * BD));
            check("read_busy_fall", 64'(fall - tx_starts[3]), 64'(10 * BD));
        end

        // unknown command
        exp_tx.push_back(8'h3F);
        send_byte(8'h41, 1'b1);
        wait_idle(fall);

        // glitch shorter than half a bit
        ser_rx = 1'b0;
        repeat (BD / 2 - 2) @(negedge clk);
        ser_rx = 1'b1;
        any_busy = 0;
        repeat (20 * BD) begin
            @(negedge clk);
            if (busy !== 1'b0)
                any_busy = 1;
        end
        check("glitch_ignored", 64'(any_busy), 64'd0);

        // bus timeout
        rdy_dly = -1;
        push_bus(32'hF000_0000, 32'hDEAD_BEEF, 4'h0, BT);
        exp_tx.push_back(8'h54);
        send_byte(8'h52, 1'b1);
        send4(32'hF000_0000);
        wait_idle(fall);

        // framing error on an address byte
        rdy_dly = 1;
        push_bus(32'h0300_0010, 32'h0403_0201, 4'hF, 2);
        exp_tx.push_back(8'h4B);
        send_byte(8'h57, 1'b1);
        send_byte(8'hAA, 1'b0);
        send4(32'h0300_0010);
        send4(32'h0403_0201);
        wait_idle(fall);

        // inter-byte stall, then a normal read
        send_byte(8'h52, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (IT + 2 * BD) @(negedge clk);
        check("idle_timeout_busy", 64'(busy), 64'd0);
        rdy_dly = 0;
        rdata_cfg = 32'hA5A5_0F0F;
        push_bus(32'h0000_0008, 32'h0403_0201, 4'h0, 1);
        exp_tx.push_back(8'h0F);
        exp_tx.push_back(8'h0F);
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'hA5);
        send_byte(8'h52, 1'b1);
        send4(32'h0000_0008);
        wait_idle(fall);

        // reset while mem_valid is high
        rdy_dly = -1;
        push_bus(32'h0000_000C, 32'h0403_0201, 4'h0, -1);
        send_byte(8'h52, 1'b1);
        send4(32'h0000_000C);
        wait_valid();
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_bus_valid_drop", 64'(mem_valid), 64'd0);
        check("rst_bus_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // reset in the middle of a TX byte
        send_byte(8'h41, 1'b1);
        begin
            int n;
            n = 0;
            while (ser_tx !== 1'b0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("tx_start_wait_bound", 64'(n < 2000), 64'd1);
        end
        repeat (3 * BD) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_tx_line_high", 64'(ser_tx), 64'd1);
        check("rst_tx_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        repeat (10 * BD) @(negedge clk);

        // write after reset
        rdy_dly = 2;
        push_bus(32'h0000_0020, 32'h1234_5678, 4'hF, 3);
        exp_tx.push_back(8'h4B);
        send_byte(8'h57, 1'b1);
        send4(32'h0000_0020);
        send4(32'h1234_5678);
        wait_idle(fall);

        repeat (4 * BD) @(negedge clk);
        check("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
        check("bus_queue_drained", 64'(exp_bus.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Serial debug bridge: the bus-initiator counterpart to the SoC's memory-mapped UART responder.
- Receives command frames on ser_rx and issues single 32-bit transactions on the PicoRV32 native memory interface as initiator.
- Returns results on ser_tx.
- Sits beside the CPU on the bus arbiter so a host can peek/poke memory and peripherals without firmware.

Parameters:
BAUD_DIV, 104, bit period in clk cycles (legal >= 4)
BUS_TIMEOUT, 1024, max cycles mem_valid is held waiting for mem_ready
IDLE_TIMEOUT, 1000000, max clk cycles between bytes of one command frame

Ports:
clk  input  1  clock
resetn  input  1  synchronous, active-low reset
ser_rx  input  1  serial in, idle high, asynchronous to clk
ser_tx  output  1  serial out, idle high
mem_valid  output  1  transaction request
mem_addr  output  32  byte address
mem_wdata  output  32  write data
mem_wstrb  output  4  byte enables; 4'hF = write, 4'h0 = read
mem_ready  input  1  responder completion
mem_rdata  input  32  read data, valid when mem_ready=1
busy  output  1  high whenever the parser is not in IDLE

Behaviour:
- Reset: resetn is synchronous, active-low; clock clk. Reset values: ser_tx=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0. All FSMs go to idle and partial frames are discarded. Reset mid-transaction drops mem_valid on the next edge, and any in-flight TX byte is abandoned (line forced to 1).
- ser_rx synchroniser: 2-flop, so input latency is 2 cycles.
- RX:
  - Start-bit detect: falling edge of the synchronised line.
  - At BAUD_DIV/2 (integer divide) re-sample. If high, treat as a glitch and return to idle.
  - Then sample 8 data bits LSB-first, one every BAUD_DIV cycles, then the stop bit.
  - Stop=0 is a framing error: the byte is dropped and parser state is unchanged.
  - Good byte: produces a 1-cycle rx_strobe.
- TX:
  - 10-bit frame: start 0, 8 data bits LSB-first, stop 1; each bit held exactly BAUD_DIV cycles.
  - Multi-byte responses are sent back-to-back with no idle gap.
  - First start bit appears 1 cycle after the parser enters RESP.
- Parser states and transitions:
  - IDLE: on rx byte 0x57 'W' -> ADDR (write); 0x52 'R' -> ADDR (read); any other byte -> RESP with response 0x3F '?'.
  - ADDR: collect 4 bytes, little-endian, into mem_addr. Then write -> DATA, read -> BUS.
  - DATA: collect 4 bytes, little-endian, into mem_wdata -> BUS.
  - BUS entry: mem_valid=1 on the edge after the final byte's rx_strobe; mem_wstrb = F (write) or 0 (read). addr, wdata and wstrb stay stable while mem_valid=1.
  - BUS, mem_ready=1 sampled on an edge: capture mem_rdata; mem_valid=0 the following cycle. mem_ready with mem_valid=0 is ignored.
  - BUS success responses: write -> 0x4B 'K'; read -> 4 rdata bytes, LSB first.
  - BUS timeout: counter reaches BUS_TIMEOUT with no mem_ready -> mem_valid=0, response 0x54 'T'. mem_ready arriving on the same edge as the timeout counts as success.
  - RESP: send the queued bytes, then -> IDLE (busy=0 on the cycle after the last stop bit completes).
  - ADDR/DATA inter-byte timer: reset on every rx byte. At IDLE_TIMEOUT -> IDLE silently, no response.
- RX bytes completing while in BUS or RESP are discarded. The receiver itself keeps running so framing stays aligned.
- mem_addr and mem_wdata retain their last values after a transaction; they are only updated by byte collection.

Test Plan:
- Write: send 57 10 00 00 02 EF BE AD DE; responder asserts mem_ready after 3 cycles -> mem_valid held 3+ cycles, mem_addr=0x02000010, mem_wdata=0xDEADBEEF, wstrb=F; ser_tx returns 0x4B; each bit BAUD_DIV cycles wide.
- Read: send 52 04 00 00 00, mem_rdata=0x12345678 with immediate mem_ready -> wstrb=0, single-cycle mem_valid; ser_tx returns 78 56 34 12 back-to-back; busy falls after the last stop bit.
- Unknown command: send 0x41 -> response 0x3F, no mem_valid.
- Bus timeout: read to an address whose responder never asserts mem_ready -> mem_valid high exactly BUS_TIMEOUT cycles, then 0x54.
- Framing and timing faults: a low pulse shorter than BAUD_DIV/2 -> no byte received. Stop bit forced 0 during a 'W' address byte -> byte dropped, frame completes after one extra byte. Stall of IDLE_TIMEOUT after 'R' 01 -> silent return to IDLE; next 'R' frame is accepted normally.
- Reset: assert resetn=0 while mem_valid=1 and mid-TX -> next edge mem_valid=0 and ser_tx=1; a subsequent write completes normally.
